// File: rtl/mnist_argmax_collector.sv
// Streaming signed argmax over NUM_CLASSES logits with a handshaked prediction, watchdog and drop flags.
// Optional build macro ARGMAX_LOGITS_EN adds a per-frame logit register file with registered readback.
module mnist_argmax_collector #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CLASSES    = 10,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int TO_WIDTH       = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         pred_valid,
    input  logic                         pred_ready,
    output logic        [IDX_WIDTH-1:0]  pred_class,
    output logic signed [DATA_WIDTH-1:0] pred_max,
    output logic        [15:0]           frame_cnt,
    output logic                         err_drop,
    output logic                         err_timeout,
    input  logic        [IDX_WIDTH-1:0]  rd_idx,
    output logic        [DATA_WIDTH-1:0] rd_data
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t                       r_state, w_state_nxt;
    logic signed [DATA_WIDTH-1:0] r_best;
    logic        [IDX_WIDTH-1:0]  r_best_idx;
    logic        [IDX_WIDTH-1:0]  r_cnt;
    logic        [TO_WIDTH-1:0]   r_wd;

    logic w_start, w_accum, w_last, w_drop, w_timeout, w_greater;

    assign w_greater = (in_data > r_best);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accum     = 1'b0;
        w_last      = 1'b0;
        w_drop      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    w_accum = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (r_wd == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                // A logit arriving with the handshake opens the next frame instead of being dropped
                if (pred_ready) begin
                    if (in_valid) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (in_valid) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best      <= '0;
            r_best_idx  <= '0;
            r_cnt       <= '0;
            r_wd        <= '0;
            pred_valid  <= 1'b0;
            pred_class  <= '0;
            pred_max    <= '0;
            frame_cnt   <= '0;
            err_drop    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_drop    <= w_drop;
            err_timeout <= w_timeout;
            if (w_last) begin
                pred_valid <= 1'b1;
                pred_class <= w_greater ? r_cnt : r_best_idx;
                pred_max   <= w_greater ? in_data : r_best;
                frame_cnt  <= frame_cnt + 16'd1;
            end else if (pred_valid && pred_ready) begin
                pred_valid <= 1'b0;
            end

            if (w_start) begin
                r_best     <= in_data;
                r_best_idx <= '0;
                r_cnt      <= IDX_WIDTH'(1);
                r_wd       <= '0;
            end else if (w_accum) begin
                // Strict compare keeps the lowest index on ties
                if (w_greater) begin
                    r_best     <= in_data;
                    r_best_idx <= r_cnt;
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                r_wd  <= '0;
            end else if (w_timeout) begin
                r_cnt <= '0;
                r_wd  <= '0;
            end else if (r_state == S_ACCUM) begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

`ifdef ARGMAX_LOGITS_EN
    logic signed [DATA_WIDTH-1:0] r_logits [NUM_CLASSES];

    always_ff @(posedge clk) begin
        if (w_start)      r_logits[0]     <= in_data;
        else if (w_accum) r_logits[r_cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         rd_data <= '0;
        else if (int'(rd_idx) < NUM_CLASSES) rd_data <= r_logits[rd_idx];
        else                                rd_data <= '0;
    end
`else
    logic w_unused_rd_idx;
    assign w_unused_rd_idx = ^rd_idx;
    assign rd_data         = '0;
`endif

endmodule

// File: tb/tb_mnist_argmax_collector.sv
// Self-checking bench for mnist_argmax_collector: vector table, hand-written corner sequences and
// randomized frames compared against a max-then-first-index reference model.
module tb_mnist_argmax_collector;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               pred_valid;
    logic               pred_ready;
    logic [3:0]         pred_class;
    logic signed [31:0] pred_max;
    logic [15:0]        frame_cnt;
    logic               err_drop;
    logic               err_timeout;
    logic [3:0]         rd_idx;
    logic [31:0]        rd_data;

    always #5 clk = ~clk;

    mnist_argmax_collector #(
        .DATA_WIDTH(32), .NUM_CLASSES(10), .IDX_WIDTH(4),
        .TIMEOUT_CYCLES(20), .TO_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_class(pred_class),
        .pred_max(pred_max), .frame_cnt(frame_cnt), .err_drop(err_drop),
        .err_timeout(err_timeout), .rd_idx(rd_idx), .rd_data(rd_data)
    );

    typedef struct {
        logic [0:9][31:0] l;
        logic [3:0]       cls;
        logic [31:0]      mx;
    } vec_t;

    vec_t               tbl [5];
    logic signed [31:0] cur [10];
    int                 n_checks = 0;
    int                 n_err    = 0;
    int                 exp_frames = 0;
    logic [3:0]         last_cls = '0;
    logic signed [31:0] last_max = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: find the maximum value, then the first index holding it.
    task automatic model(output logic [3:0] cls, output logic signed [31:0] mx);
        mx = cur[0];
        foreach (cur[i]) if (cur[i] > mx) mx = cur[i];
        cls = '0;
        for (int i = 9; i >= 0; i--) if (cur[i] == mx) cls = 4'(i);
    endtask

    task automatic send_frame(input int first, input int maxgap);
        for (int i = first; i < 10; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = cur[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_pred(input string tag);
        logic [3:0]         c;
        logic signed [31:0] m;
        model(c, m);
        check({tag, "_valid"}, pred_valid, 1);
        check({tag, "_class"}, pred_class, c);
        check({tag, "_max"}, pred_max, m);
        check({tag, "_frames"}, frame_cnt, 16'(exp_frames));
        last_cls = c;
        last_max = m;
    endtask

    task automatic rand_frame(input bit narrow);
        foreach (cur[i]) cur[i] = narrow ? 32'($urandom_range(0, 7)) - 32'sd4 : 32'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pred_valid"}, pred_valid, 0);
        check({tag, "_pred_class"}, pred_class, 0);
        check({tag, "_pred_max"}, pred_max, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_err_drop"}, err_drop, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    initial begin
        int first_k, pulses;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; pred_ready = 1'b0; rd_idx = '0;
        repeat (3) tick();
        check_reset_vals("rst");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Directed vector table
        tbl[0].l = {32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd11};
        tbl[0].cls = 4'd2; tbl[0].mx = 32'd12;
        for (int i = 0; i < 10; i++) tbl[1].l[i] = (i == 6) ? -32'sd1 : -32'sd100;
        tbl[1].cls = 4'd6; tbl[1].mx = 32'hFFFF_FFFF;
        tbl[2].l = {32'sd9, 32'sd9, 32'sd3, 32'sd1, 32'sd2, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8};
        tbl[2].cls = 4'd0; tbl[2].mx = 32'd9;
        for (int i = 0; i < 10; i++) tbl[3].l[i] = (i == 9) ? 32'h7FFF_FFFF : 32'h8000_0000;
        tbl[3].cls = 4'd9; tbl[3].mx = 32'h7FFF_FFFF;
        for (int i = 0; i < 10; i++) tbl[4].l[i] = 32'h8000_0000;
        tbl[4].cls = 4'd0; tbl[4].mx = 32'h8000_0000;

        pred_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 10; i++) cur[i] = tbl[k].l[i];
            send_frame(0, 0);
            exp_frames++;
            check($sformatf("tbl%0d_valid", k), pred_valid, 1);
            check($sformatf("tbl%0d_class", k), pred_class, tbl[k].cls);
            check($sformatf("tbl%0d_max", k), pred_max, 64'(signed'(tbl[k].mx)));
            check($sformatf("tbl%0d_frames", k), frame_cnt, 16'(exp_frames));
            tick();
            check($sformatf("tbl%0d_valid_1cyc", k), pred_valid, 0);
            last_cls = tbl[k].cls;
            last_max = tbl[k].mx;
        end

        // Logit readback
        rand_frame(1'b0);
        send_frame(0, 0);
        exp_frames++;
        check_pred("rb_frame");
        tick();
        for (int i = 0; i < 10; i++) begin
            rd_idx = 4'(i);
            tick();
`ifdef ARGMAX_LOGITS_EN
            check($sformatf("rd_data_%0d", i), rd_data, 64'(cur[i]));
`else
            check($sformatf("rd_data_tied_%0d", i), rd_data, 0);
`endif
        end
        rd_idx = 4'd12;
        tick();
        check("rd_data_oob", rd_data, 0);

        // Drops while prediction is held, then handshake together with a new logit
        pred_ready = 1'b0;
        for (int i = 0; i < 10; i++) cur[i] = tbl[0].l[i];
        send_frame(0, 0);
        exp_frames++;
        check_pred("hold_frame");
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = 32'($urandom);
            tick();
            check($sformatf("drop%0d_pulse", j), err_drop, 1);
            check($sformatf("drop%0d_valid", j), pred_valid, 1);
            check($sformatf("drop%0d_class", j), pred_class, 2);
            check($sformatf("drop%0d_max", j), pred_max, 12);
        end
        in_valid = 1'b0;
        tick();
        check("drop_end", err_drop, 0);
        check("drop_end_valid", pred_valid, 1);
        for (int i = 0; i < 10; i++) cur[i] = tbl[1].l[i];
        in_valid = 1'b1; pred_ready = 1'b1; in_data = cur[0];
        tick();
        check("hs_nodrop", err_drop, 0);
        check("hs_valid_low", pred_valid, 0);
        send_frame(1, 0);
        exp_frames++;
        check_pred("hs_frame");
        tick();

        // Watchdog fires on the 20th idle cycle after the last accepted logit
        rand_frame(1'b0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = cur[i];
            tick();
        end
        in_valid = 1'b0;
        first_k = -1; pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (err_timeout) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("to_cycle", 64'(first_k), 20);
        check("to_pulses", 64'(pulses), 1);
        check("to_valid", pred_valid, 0);
        check("to_frames", frame_cnt, 16'(exp_frames));
        check("to_class_kept", pred_class, last_cls);
        check("to_max_kept", pred_max, last_max);
        rand_frame(1'b1);
        send_frame(0, 0);
        exp_frames++;
        check_pred("after_to");
        tick();

        // 19 idle cycles inside a frame must not trip the watchdog
        rand_frame(1'b0);
        send_frame(0, 0);
        exp_frames++;
        tick();
        rand_frame(1'b0);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = cur[i];
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 19; k++) begin
            tick();
            if (err_timeout) pulses++;
        end
        send_frame(2, 0);
        exp_frames++;
        check("to19_none", 64'(pulses), 0);
        check_pred("to19_frame");

        // Randomized frames with gaps and back-to-back starts
        for (int f = 0; f < 30; f++) begin
            rand_frame(f[0]);
            send_frame(0, (f % 3 == 0) ? 0 : 3);
            exp_frames++;
            check_pred($sformatf("rnd%0d", f));
            check($sformatf("rnd%0d_nodrop", f), err_drop, 0);
        end
        tick();

        // Asynchronous reset in the middle of a frame
        rand_frame(1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = cur[i];
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        in_valid = 1'b0;
        tick();
        @(negedge clk) rst_n = 1'b1;
        exp_frames = 0;
        rand_frame(1'b1);
        send_frame(0, 0);
        exp_frames++;
        check_pred("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mnist_argmax_collector.md
# mnist_argmax_collector

Streaming classifier back-end for the MNIST network core. Collects `NUM_CLASSES` signed logits from the final FC layer's `result`/`result_valid` stream, computes the signed argmax, and presents the predicted class with a valid/ready handshake to downstream display or UART logic. It adds a partial-frame watchdog, drop detection, and a frame counter. Parametrised in logit width, class count and timeout, it is the synthesizable successor to the bench-side argmax check.

## Interface
- `DATA_WIDTH`, default 32: logit width, two's complement.
- `NUM_CLASSES`, default 10: logits per frame, range 2..256.
- `IDX_WIDTH`, default 4: class index width. Must satisfy 2^IDX_WIDTH >= NUM_CLASSES.
- `TIMEOUT_CYCLES`, default 5000000: maximum idle cycles allowed inside a partial frame. Must be at least 1.
- `TO_WIDTH`, default 23: watchdog counter width. Must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: logit strobe, one logit per cycle when high.
- `in_data`  in  DATA_WIDTH: signed logit.
- `pred_valid`  out  1: prediction available. Held until accepted.
- `pred_ready`  in  1: downstream accepts the prediction.
- `pred_class`  out  IDX_WIDTH: argmax index.
- `pred_max`  out  DATA_WIDTH: maximum logit value.
- `frame_cnt`  out  16: completed frames, wraps from 0xFFFF to 0.
- `err_drop`  out  1: one-cycle pulse when a logit is discarded.
- `err_timeout`  out  1: one-cycle pulse when a partial frame is aborted.
- `rd_idx`  in  IDX_WIDTH: logit readback index (used only with `ARGMAX_LOGITS_EN`).
- `rd_data`  out  DATA_WIDTH: stored logit at `rd_idx`.

## Operation
- The state machine has three states: IDLE, ACCUM and HOLD. Reset enters IDLE.
- **IDLE**
  - `in_valid` loads best=`in_data`, best_idx=0 and cnt=1, then moves to ACCUM.
  - If NUM_CLASSES is 1, this is not a supported configuration (range is 2..256).
- **ACCUM**
  - Each `in_valid` compares `in_data` against best as a signed compare.
  - Best is updated only on strict greater-than, so ties keep the lower index.
  - The cnt increments on every accepted logit.
  - When the logit with index NUM_CLASSES-1 is accepted, the final best is registered to `pred_class`/`pred_max`. `pred_valid` is set, `frame_cnt` increments, and the state moves to HOLD.
- **HOLD**
  - `pred_*` is stable while `pred_valid` is high and `pred_ready` is low.
  - `pred_valid && pred_ready` returns to IDLE.
  - `in_valid` while in HOLD without `pred_ready`: the logit is dropped and `err_drop` pulses. Dropped logits are not queued.
  - `in_valid` and `pred_ready` in the same HOLD cycle: the handshake completes and the logit is accepted as index 0 of a new frame. The state goes directly to ACCUM with cnt=1, and `err_drop` stays 0.
- **Watchdog**
  - The idle counter runs only in ACCUM. It clears on each `in_valid`.
  - When it reaches TIMEOUT_CYCLES, the frame is discarded. `err_timeout` pulses, the state returns to IDLE, and `pred_*` is unchanged.
- **Reset mid-operation:** reset forces IDLE immediately. The partial frame is lost.

## Timing
- Reset values:
  - `pred_valid`=0, `pred_class`=0, `pred_max`=0.
  - `frame_cnt`=0, `err_drop`=0, `err_timeout`=0.
  - `rd_data`=0.
  - Internal cnt, best and the watchdog counter all reset to 0.
- Latency: `pred_valid` rises on the clock edge that samples the last logit (registered output). Downstream sees it one cycle after the last `in_valid` cycle.
- Throughput: back-to-back frames with no gap are allowed only if `pred_ready` is high at the first logit of the next frame.
- Error pulses are registered and last exactly one cycle.
- The watchdog fires exactly TIMEOUT_CYCLES cycles after the last accepted logit of a partial frame.
- `rd_data` is registered: it returns the value at `rd_idx` one cycle later.

## Configuration
- `ARGMAX_LOGITS_EN` defined:
  - A NUM_CLASSES × DATA_WIDTH register file stores every accepted logit of the current frame, written at its index.
  - `rd_data` returns `logit[rd_idx]`. An `rd_idx` of NUM_CLASSES or above returns 0.
  - A timed-out frame leaves the entries it had written.
- `ARGMAX_LOGITS_EN` undefined: no storage is built and `rd_data` is tied to 0.

## Test plan
- Logits {5,-3,12,7,0,1,2,3,4,11} with `pred_ready`=1 → `pred_class`=2, `pred_max`=12. `pred_valid` lasts 1 cycle and `frame_cnt`=1.
- All logits −100 except index 6 = −1 → `pred_class`=6, `pred_max`=−1, which checks the signed compare.
- Logits {9,9,3,…} tie → `pred_class`=0. Also feed 0x7FFFFFFF at index 9 against 0x80000000 elsewhere → `pred_class`=9.
- Hold `pred_ready`=0, then send 3 extra logits → 3 `err_drop` pulses and `pred_*` stable. Raise `pred_ready` together with `in_valid` → no drop, and a second frame completes with `frame_cnt`=2.
- TIMEOUT_CYCLES=20: send 4 logits, then idle → `err_timeout` pulses on exactly the 20th idle cycle. `pred_valid` stays 0, and the next full frame classifies correctly.
- With `ARGMAX_LOGITS_EN` defined: after the first frame, sweep `rd_idx` 0..9 → `rd_data` matches the inputs with 1-cycle latency, and `rd_idx`=12 returns 0. Assert `rst_n` low mid-frame → all outputs return to reset values immediately.
